// File: rtl/hazard_scoreboard_pkg.sv
// rtl/hazard_scoreboard_pkg.sv - shared defaults, register-file ids and helpers for the load-use scoreboard
package hazard_scoreboard_pkg;

    localparam int DEF_NUM_RF   = 2;
    localparam int DEF_NUM_REGS = 16;
    localparam int DEF_REG_W    = 4;
    localparam int DEF_NUM_SRC  = 2;
    localparam int DEF_LOAD_LAT = 3;
    localparam int DEF_ZERO_REG = 1;
    localparam int DEF_CNT_W    = 16;

    localparam int RF_GP = 0;
    localparam int RF_SR = 1;

    // Countdown width large enough to hold LOAD_LAT; never narrower than one bit.
    function automatic int cd_width(input int lat);
        return (lat < 1) ? 1 : $clog2(lat + 1);
    endfunction

endpackage

// File: rtl/hazard_scoreboard_rf.sv
// rtl/hazard_scoreboard_rf.sv - one register file's load countdowns, mark/decay and hazard compare
module hazard_scoreboard_rf
    import hazard_scoreboard_pkg::*;
#(
    parameter int NUM_REGS = DEF_NUM_REGS,
    parameter int REG_W    = DEF_REG_W,
    parameter int NUM_SRC  = DEF_NUM_SRC,
    parameter int LOAD_LAT = DEF_LOAD_LAT,
    parameter int ZERO_REG = DEF_ZERO_REG
)(
    input  logic                       i_clk,
    input  logic                       i_rst,
    input  logic                       i_fire,
    input  logic                       i_hold,
    input  logic                       i_is_load,
    input  logic [REG_W-1:0]           i_tgt,
    input  logic                       i_tgt_we,
    input  logic [NUM_SRC*REG_W-1:0]   i_src,
    input  logic [NUM_SRC-1:0]         i_src_re,
    output logic                       o_hazard,
    output logic [NUM_REGS-1:0]        o_pending
);

    localparam int              CD_W    = cd_width(LOAD_LAT);
    localparam logic [CD_W-1:0] CD_LOAD = CD_W'(LOAD_LAT);

    logic [CD_W-1:0]     r_cd [NUM_REGS];
    logic [NUM_REGS-1:0] w_mark;
    logic [NUM_SRC-1:0]  w_src_hit;
    logic                w_waw_hit;

    function automatic logic is_zero_reg(input logic [REG_W-1:0] idx);
        return (ZERO_REG != 0) && (idx == '0);
    endfunction

    always_comb begin
        w_mark = '0;
        for (int r = 0; r < NUM_REGS; r++) begin
            w_mark[r] = i_fire & i_is_load & i_tgt_we & (i_tgt == REG_W'(r))
                        & ~is_zero_reg(REG_W'(r));
        end
    end

    // A marked register always held 0 (WAW would have stalled otherwise), so mark simply wins.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            for (int r = 0; r < NUM_REGS; r++) begin
                r_cd[r] <= '0;
            end
        end else begin
            for (int r = 0; r < NUM_REGS; r++) begin
                if (w_mark[r]) begin
                    r_cd[r] <= CD_LOAD;
                end else if (!i_hold && (r_cd[r] != '0)) begin
                    r_cd[r] <= r_cd[r] - 1'b1;
                end
            end
        end
    end

    always_comb begin
        o_pending = '0;
        for (int r = 0; r < NUM_REGS; r++) begin
            o_pending[r] = (r_cd[r] != '0);
        end
    end

    always_comb begin
        logic [REG_W-1:0] idx;
        idx       = '0;
        w_src_hit = '0;
        for (int k = 0; k < NUM_SRC; k++) begin
            idx          = i_src[k*REG_W +: REG_W];
            w_src_hit[k] = i_src_re[k] & o_pending[idx] & ~is_zero_reg(idx);
        end
        w_waw_hit = i_tgt_we & o_pending[i_tgt] & ~is_zero_reg(i_tgt);
    end

    assign o_hazard = (|w_src_hit) | w_waw_hit;

endmodule

// File: rtl/hazard_scoreboard.sv
// rtl/hazard_scoreboard.sv - load-use interlock: per-file scoreboards, stall/issue qualification, stall counter
module hazard_scoreboard
    import hazard_scoreboard_pkg::*;
#(
    parameter int NUM_RF   = DEF_NUM_RF,
    parameter int NUM_REGS = DEF_NUM_REGS,
    parameter int REG_W    = DEF_REG_W,
    parameter int NUM_SRC  = DEF_NUM_SRC,
    parameter int LOAD_LAT = DEF_LOAD_LAT,
    parameter int ZERO_REG = DEF_ZERO_REG,
    parameter int CNT_W    = DEF_CNT_W
)(
    input  logic                             iw_clk,
    input  logic                             iw_rst,
    input  logic                             iw_issue_valid,
    input  logic                             iw_flush,
    input  logic                             iw_hold,
    input  logic [NUM_RF-1:0]                iw_is_load,
    input  logic [NUM_RF*REG_W-1:0]          iw_tgt,
    input  logic [NUM_RF-1:0]                iw_tgt_we,
    input  logic [NUM_RF*NUM_SRC*REG_W-1:0]  iw_src,
    input  logic [NUM_RF*NUM_SRC-1:0]        iw_src_re,
    output logic                             ow_stall,
    output logic [NUM_RF*NUM_REGS-1:0]       ow_pending,
    output logic [CNT_W-1:0]                 ow_stall_cnt
);

    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    logic [NUM_RF-1:0] w_hazard;
    logic              w_stall;
    logic              w_fire;
    logic [CNT_W-1:0]  r_stall_cnt;

    for (genvar f = 0; f < NUM_RF; f++) begin : g_rf
        hazard_scoreboard_rf #(
            .NUM_REGS (NUM_REGS),
            .REG_W    (REG_W),
            .NUM_SRC  (NUM_SRC),
            .LOAD_LAT (LOAD_LAT),
            .ZERO_REG (ZERO_REG)
        ) u_rf (
            .i_clk     (iw_clk),
            .i_rst     (iw_rst),
            .i_fire    (w_fire),
            .i_hold    (iw_hold),
            .i_is_load (iw_is_load[f]),
            .i_tgt     (iw_tgt[f*REG_W +: REG_W]),
            .i_tgt_we  (iw_tgt_we[f]),
            .i_src     (iw_src[f*NUM_SRC*REG_W +: NUM_SRC*REG_W]),
            .i_src_re  (iw_src_re[f*NUM_SRC +: NUM_SRC]),
            .o_hazard  (w_hazard[f]),
            .o_pending (ow_pending[f*NUM_REGS +: NUM_REGS])
        );
    end

    // Stall is not gated by hold: decode must stay frozen on a hazard whether or not the pipe moves.
    assign w_stall  = iw_issue_valid & ~iw_flush & (|w_hazard);
    assign w_fire   = iw_issue_valid & ~w_stall & ~iw_flush & ~iw_hold;
    assign ow_stall = w_stall;

    always_ff @(posedge iw_clk or posedge iw_rst) begin
        if (iw_rst) begin
            r_stall_cnt <= '0;
        end else if (w_stall && !iw_hold && (r_stall_cnt != CNT_MAX)) begin
            r_stall_cnt <= r_stall_cnt + 1'b1;
        end
    end

    assign ow_stall_cnt = r_stall_cnt;

endmodule

// File: tb/tb_hazard_scoreboard.sv
// tb/tb_hazard_scoreboard.sv - self-checking bench for hazard_scoreboard against a ready-time model
module tb_hazard_scoreboard;

    localparam int NRF = 2;
    localparam int NRG = 16;
    localparam int LAT = 3;
    localparam int CW  = 4;
    localparam int CMAX = 15;

    logic        iw_clk = 1'b0;
    logic        iw_rst;
    logic        iw_issue_valid;
    logic        iw_flush;
    logic        iw_hold;
    logic [1:0]  iw_is_load;
    logic [7:0]  iw_tgt;
    logic [1:0]  iw_tgt_we;
    logic [15:0] iw_src;
    logic [3:0]  iw_src_re;
    logic        ow_stall;
    logic [31:0] ow_pending;
    logic [3:0]  ow_stall_cnt;

    int tests_run = 0;
    int tests_failed = 0;

    // Model: a register is pending until the count of non-hold cycles reaches its ready time.
    int unsigned m_act = 0;
    int unsigned m_ready [NRF][NRG];
    int          m_cnt = 0;

    hazard_scoreboard #(
        .NUM_RF(NRF), .NUM_REGS(NRG), .REG_W(4), .NUM_SRC(2),
        .LOAD_LAT(LAT), .ZERO_REG(1), .CNT_W(CW)
    ) dut (
        .iw_clk(iw_clk), .iw_rst(iw_rst), .iw_issue_valid(iw_issue_valid),
        .iw_flush(iw_flush), .iw_hold(iw_hold), .iw_is_load(iw_is_load),
        .iw_tgt(iw_tgt), .iw_tgt_we(iw_tgt_we), .iw_src(iw_src),
        .iw_src_re(iw_src_re), .ow_stall(ow_stall), .ow_pending(ow_pending),
        .ow_stall_cnt(ow_stall_cnt)
    );

    always #5 iw_clk = ~iw_clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic bit m_pend(int f, int r);
        return m_act < m_ready[f][r];
    endfunction

    function automatic logic [31:0] m_pend_vec();
        logic [31:0] v;
        v = '0;
        for (int f = 0; f < NRF; f++)
            for (int r = 0; r < NRG; r++)
                v[f*NRG + r] = m_pend(f, r);
        return v;
    endfunction

    function automatic bit m_stall();
        bit haz;
        haz = 0;
        for (int f = 0; f < NRF; f++) begin
            for (int k = 0; k < 2; k++)
                if (iw_src_re[f*2+k] && m_pend(f, int'(iw_src[(f*2+k)*4 +: 4]))) haz = 1;
            if (iw_tgt_we[f] && m_pend(f, int'(iw_tgt[f*4 +: 4]))) haz = 1;
        end
        return iw_issue_valid && !iw_flush && haz;
    endfunction

    task automatic model_reset();
        for (int f = 0; f < NRF; f++)
            for (int r = 0; r < NRG; r++)
                m_ready[f][r] = 0;
        m_cnt = 0;
    endtask

    task automatic tick();
        bit s;
        bit fire;
        s    = m_stall();
        fire = iw_issue_valid && !s && !iw_flush && !iw_hold;
        if (fire)
            for (int f = 0; f < NRF; f++)
                if (iw_is_load[f] && iw_tgt_we[f] && iw_tgt[f*4 +: 4] != 4'd0)
                    m_ready[f][int'(iw_tgt[f*4 +: 4])] = m_act + 1 + LAT;
        if (s && !iw_hold && m_cnt < CMAX) m_cnt++;
        if (!iw_hold) m_act++;
        @(posedge iw_clk);
        #1;
    endtask

    task automatic clr();
        iw_issue_valid = 0; iw_flush = 0; iw_hold = 0;
        iw_is_load = '0; iw_tgt = '0; iw_tgt_we = '0; iw_src = '0; iw_src_re = '0;
    endtask

    task automatic set_load(int f, int r);
        iw_issue_valid = 1; iw_is_load[f] = 1; iw_tgt_we[f] = 1; iw_tgt[f*4 +: 4] = 4'(r);
    endtask

    task automatic set_write(int f, int r);
        iw_issue_valid = 1; iw_tgt_we[f] = 1; iw_tgt[f*4 +: 4] = 4'(r);
    endtask

    task automatic set_read(int f, int k, int r);
        iw_issue_valid = 1; iw_src_re[f*2+k] = 1; iw_src[(f*2+k)*4 +: 4] = 4'(r);
    endtask

    task automatic do_reset();
        clr();
        iw_rst = 1;
        model_reset();
        @(posedge iw_clk);
        #1;
        iw_rst = 0;
    endtask

    task automatic test_reset();
        clr();
        iw_rst = 1;
        model_reset();
        @(negedge iw_clk);
        tests_run++;
        if (ow_pending !== 32'h0 || ow_stall !== 1'b0 || ow_stall_cnt !== 4'h0) begin
            tests_failed++;
            $display("FAIL reset_state: pending=%h stall=%b cnt=%0d, required 0/0/0", ow_pending, ow_stall, ow_stall_cnt);
        end
        @(posedge iw_clk);
        #1;
        iw_rst = 0;
    endtask

    task automatic test_load_use();
        do_reset();
        set_load(0, 5);
        @(negedge iw_clk);
        tests_run++;
        if (ow_stall !== 1'b0) begin
            tests_failed++; $display("FAIL load_use_t0: stall=%b required 0", ow_stall);
        end
        tick();
        clr();
        set_read(0, 0, 5);
        for (int i = 1; i <= 4; i++) begin
            @(negedge iw_clk);
            tests_run++;
            if (ow_stall !== (i <= 3)) begin
                tests_failed++; $display("FAIL load_use_t%0d: stall=%b required %b", i, ow_stall, (i <= 3));
            end
            tick();
        end
        @(negedge iw_clk);
        tests_run++;
        if (ow_stall_cnt !== 4'd3) begin
            tests_failed++; $display("FAIL load_use_cnt: cnt=%0d required 3", ow_stall_cnt);
        end
    endtask

    task automatic test_separate_files();
        do_reset();
        set_load(1, 2);
        tick();
        clr();
        set_read(0, 1, 2);
        @(negedge iw_clk);
        tests_run++;
        if (ow_stall !== 1'b0) begin
            tests_failed++; $display("FAIL sep_gp_read: stall=%b required 0", ow_stall);
        end
        do_reset();
        set_load(1, 2);
        tick();
        clr();
        set_read(1, 1, 2);
        for (int i = 1; i <= 4; i++) begin
            @(negedge iw_clk);
            tests_run++;
            if (ow_stall !== (i <= 3)) begin
                tests_failed++; $display("FAIL sep_sr_read_t%0d: stall=%b required %b", i, ow_stall, (i <= 3));
            end
            tick();
        end
    endtask

    task automatic test_waw_zero();
        do_reset();
        set_load(0, 7);
        tick();
        clr();
        set_write(0, 7);
        for (int i = 0; i < 5; i++) begin
            @(negedge iw_clk);
            tests_run++;
            if (ow_stall !== (i < 3) || ow_pending[7] !== m_pend(0, 7)) begin
                tests_failed++;
                $display("FAIL waw_c%0d: stall=%b pend7=%b required %b/%b", i, ow_stall, ow_pending[7], (i < 3), m_pend(0, 7));
            end
            tick();
        end
        clr();
        set_load(0, 0);
        set_load(1, 0);
        tick();
        clr();
        @(negedge iw_clk);
        tests_run++;
        if (ow_pending !== 32'h0) begin
            tests_failed++; $display("FAIL zero_reg_load: pending=%h required 0", ow_pending);
        end
    endtask

    task automatic test_hold();
        do_reset();
        set_load(0, 3);
        tick();
        clr();
        set_read(0, 0, 3);
        iw_hold = 1;
        for (int i = 0; i < 4; i++) begin
            @(negedge iw_clk);
            tests_run++;
            if (ow_stall !== 1'b1 || ow_pending[3] !== 1'b1 || ow_stall_cnt !== 4'd0) begin
                tests_failed++;
                $display("FAIL hold_c%0d: stall=%b pend3=%b cnt=%0d required 1/1/0", i, ow_stall, ow_pending[3], ow_stall_cnt);
            end
            tick();
        end
        iw_hold = 0;
        for (int i = 0; i < 4; i++) begin
            @(negedge iw_clk);
            tests_run++;
            if (ow_stall !== (i < 3) || ow_pending !== m_pend_vec()) begin
                tests_failed++;
                $display("FAIL hold_release_c%0d: stall=%b pending=%h required %b/%h", i, ow_stall, ow_pending, (i < 3), m_pend_vec());
            end
            tick();
        end
    endtask

    task automatic test_flush();
        do_reset();
        set_load(0, 4);
        iw_flush = 1;
        tick();
        clr();
        @(negedge iw_clk);
        tests_run++;
        if (ow_pending !== 32'h0) begin
            tests_failed++; $display("FAIL flush_no_mark: pending=%h required 0", ow_pending);
        end
        set_load(0, 4);
        tick();
        clr();
        set_read(0, 0, 4);
        iw_flush = 1;
        for (int i = 0; i < 4; i++) begin
            @(negedge iw_clk);
            tests_run++;
            if (ow_stall !== 1'b0 || ow_pending[4] !== (i < 3)) begin
                tests_failed++;
                $display("FAIL flush_decay_c%0d: stall=%b pend4=%b required 0/%b", i, ow_stall, ow_pending[4], (i < 3));
            end
            tick();
        end
    endtask

    task automatic test_async_reset();
        do_reset();
        set_load(0, 6);
        tick();
        clr();
        set_read(0, 0, 6);
        tick();
        #2;
        iw_rst = 1;
        #1;
        tests_run++;
        if (ow_pending !== 32'h0 || ow_stall !== 1'b0) begin
            tests_failed++; $display("FAIL async_reset: pending=%h stall=%b required 0/0", ow_pending, ow_stall);
        end
        model_reset();
        #3;
        iw_rst = 0;
        tick();
        @(negedge iw_clk);
        tests_run++;
        if (ow_stall !== 1'b0 || ow_pending !== 32'h0 || ow_stall_cnt !== 4'd0) begin
            tests_failed++;
            $display("FAIL after_reset: stall=%b pending=%h cnt=%0d required 0/0/0", ow_stall, ow_pending, ow_stall_cnt);
        end
    endtask

    task automatic test_saturate();
        int prev;
        int nx;
        bit s;
        do_reset();
        prev = 1;
        set_load(0, prev);
        tick();
        for (int i = 0; i < 40; i++) begin
            nx = (prev % 15) + 1;
            clr();
            set_load(0, nx);
            set_read(0, 0, prev);
            s = m_stall();
            @(negedge iw_clk);
            tests_run++;
            if (ow_stall !== s || ow_stall_cnt !== 4'(m_cnt)) begin
                tests_failed++;
                $display("FAIL sat_c%0d: stall=%b cnt=%0d required %b/%0d", i, ow_stall, ow_stall_cnt, s, m_cnt);
            end
            tick();
            if (!s) prev = nx;
        end
        @(negedge iw_clk);
        tests_run++;
        if (ow_stall_cnt !== 4'hF) begin
            tests_failed++; $display("FAIL sat_final: cnt=%0d required 15", ow_stall_cnt);
        end
    endtask

    task automatic test_random();
        bit s;
        do_reset();
        for (int i = 0; i < 400; i++) begin
            clr();
            iw_issue_valid = ($urandom_range(0, 9) < 8);
            iw_flush       = ($urandom_range(0, 9) == 0);
            iw_hold        = ($urandom_range(0, 19) < 3);
            for (int f = 0; f < NRF; f++) begin
                iw_is_load[f]     = $urandom_range(0, 1) == 1;
                iw_tgt_we[f]      = $urandom_range(0, 9) < 6;
                iw_tgt[f*4 +: 4]  = 4'($urandom_range(0, 3));
                for (int k = 0; k < 2; k++) begin
                    iw_src_re[f*2+k]          = $urandom_range(0, 1) == 1;
                    iw_src[(f*2+k)*4 +: 4]    = 4'($urandom_range(0, 3));
                end
            end
            s = m_stall();
            @(negedge iw_clk);
            tests_run++;
            if (ow_stall !== s) begin
                tests_failed++; $display("FAIL rand_stall_c%0d: stall=%b required %b", i, ow_stall, s);
            end
            tests_run++;
            if (ow_pending !== m_pend_vec()) begin
                tests_failed++; $display("FAIL rand_pending_c%0d: pending=%h required %h", i, ow_pending, m_pend_vec());
            end
            tests_run++;
            if (ow_stall_cnt !== 4'(m_cnt)) begin
                tests_failed++; $display("FAIL rand_cnt_c%0d: cnt=%0d required %0d", i, ow_stall_cnt, m_cnt);
            end
            tick();
        end
        clr();
    endtask

    initial begin
        clr();
        iw_rst = 1;
        #1;
        test_reset();
        test_load_use();
        test_separate_files();
        test_waw_zero();
        test_hold();
        test_flush();
        test_async_reset();
        test_saturate();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
